// File: rtl/mem_arbiter.sv
// Arbitrates one single-port, variable-latency memory between a two-beat instruction
// fetch port and a single-beat data port: data has priority, bounded by a starvation cap.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 16,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_flush,
    output logic                i_done,
    output logic [2*DATA_W-1:0] i_instr,
    output logic                i_stall,
    input  logic                d_req,
    input  logic                d_wr,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_done,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_stall,
    output logic                mem_req,
    output logic                mem_wr,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_I_HI,
        ST_I_LO,
        ST_D_ACC,
        ST_FLUSH_WAIT
    } state_t;

    state_t                r_state;
    logic                  r_mem_req;
    logic                  r_mem_wr;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [DATA_W-1:0]     r_mem_wdata;
    logic [DATA_W-1:0]     r_instr_hi;
    logic [2*DATA_W-1:0]   r_i_instr;
    logic                  r_i_done;
    logic [DATA_W-1:0]     r_d_rdata;
    logic                  r_d_done;
    logic [SW-1:0]         r_streak;

    state_t                w_nxt_state;
    logic                  w_nxt_mem_wr;
    logic [ADDR_W-1:0]     w_nxt_mem_addr;
    logic [DATA_W-1:0]     w_nxt_mem_wdata;
    logic [DATA_W-1:0]     w_nxt_instr_hi;
    logic [2*DATA_W-1:0]   w_nxt_i_instr;
    logic                  w_nxt_i_done;
    logic [DATA_W-1:0]     w_nxt_d_rdata;
    logic                  w_nxt_d_done;
    logic [SW-1:0]         w_nxt_streak;

    logic                  w_i_elig;
    logic                  w_d_elig;
    logic                  w_streak_full;

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (v == SW'(MAX_D_STREAK)) ? v : v + SW'(1);
    endfunction

    // A port whose done pulse is high this cycle is still holding its old request.
    assign w_d_elig      = d_req && !r_d_done;
    assign w_i_elig      = i_req && !r_i_done && !i_flush;
    assign w_streak_full = (r_streak == SW'(MAX_D_STREAK));

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_mem_wr    = r_mem_wr;
        w_nxt_mem_addr  = r_mem_addr;
        w_nxt_mem_wdata = r_mem_wdata;
        w_nxt_instr_hi  = r_instr_hi;
        w_nxt_i_instr   = r_i_instr;
        w_nxt_i_done    = 1'b0;
        w_nxt_d_rdata   = r_d_rdata;
        w_nxt_d_done    = 1'b0;
        w_nxt_streak    = r_streak;
        case (r_state)
            ST_IDLE: begin
                if (w_d_elig && !(w_i_elig && w_streak_full)) begin
                    w_nxt_state     = ST_D_ACC;
                    w_nxt_mem_addr  = d_addr;
                    w_nxt_mem_wr    = d_wr;
                    w_nxt_mem_wdata = d_wdata;
                    w_nxt_streak    = i_req ? sat_inc(r_streak) : '0;
                end else if (w_i_elig) begin
                    w_nxt_state    = ST_I_HI;
                    w_nxt_mem_addr = i_addr;
                    w_nxt_mem_wr   = 1'b0;
                    w_nxt_streak   = '0;
                end
            end
            ST_I_HI: begin
                if (mem_ack) begin
                    if (i_flush) begin
                        w_nxt_state = ST_IDLE;
                    end else begin
                        w_nxt_state    = ST_I_LO;
                        w_nxt_instr_hi = mem_rdata;
                        w_nxt_mem_addr = r_mem_addr + ADDR_W'(1);
                    end
                end else if (i_flush) begin
                    w_nxt_state = ST_FLUSH_WAIT;
                end
            end
            ST_I_LO: begin
                if (mem_ack) begin
                    w_nxt_state = ST_IDLE;
                    if (!i_flush) begin
                        w_nxt_i_instr = {r_instr_hi, mem_rdata};
                        w_nxt_i_done  = 1'b1;
                    end
                end else if (i_flush) begin
                    w_nxt_state = ST_FLUSH_WAIT;
                end
            end
            ST_D_ACC: begin
                if (mem_ack) begin
                    w_nxt_state  = ST_IDLE;
                    w_nxt_d_done = 1'b1;
                    w_nxt_mem_wr = 1'b0;
                    if (!r_mem_wr) w_nxt_d_rdata = mem_rdata;
                end
            end
            // The memory cannot abort a beat, so the cancelled one is drained and dropped.
            ST_FLUSH_WAIT: begin
                if (mem_ack) w_nxt_state = ST_IDLE;
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_instr_hi  <= '0;
            r_i_instr   <= '0;
            r_i_done    <= 1'b0;
            r_d_rdata   <= '0;
            r_d_done    <= 1'b0;
            r_streak    <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_mem_req   <= (w_nxt_state != ST_IDLE);
            r_mem_wr    <= w_nxt_mem_wr;
            r_mem_addr  <= w_nxt_mem_addr;
            r_mem_wdata <= w_nxt_mem_wdata;
            r_instr_hi  <= w_nxt_instr_hi;
            r_i_instr   <= w_nxt_i_instr;
            r_i_done    <= w_nxt_i_done;
            r_d_rdata   <= w_nxt_d_rdata;
            r_d_done    <= w_nxt_d_done;
            r_streak    <= w_nxt_streak;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_done    = r_i_done;
    assign i_instr   = r_i_instr;
    assign d_done    = r_d_done;
    assign d_rdata   = r_d_rdata;
    assign i_stall   = i_req && !r_i_done;
    assign d_stall   = d_req && !r_d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory responder with random latency, requester tasks feeding
// scoreboard queues, and a negedge monitor that checks every done pulse and bus beat.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int ADDR_W = 32, DATA_W = 16, MAX_D_STREAK = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        i_req = 1'b0, i_flush = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_done, i_stall;
    logic [31:0] i_instr;
    logic        d_req = 1'b0, d_wr = 1'b0;
    logic [31:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_done, d_stall;
    logic [15:0] d_rdata;
    logic        mem_req, mem_wr;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_D_STREAK(MAX_D_STREAK)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_done(i_done),
        .i_instr(i_instr), .i_stall(i_stall),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] a; logic w; logic [15:0] d; } beat_t;

    int          n_tests = 0, n_fail = 0;
    int          lat_force = -1;
    logic [15:0] dev_dmem [16];
    logic [15:0] ref_dmem [16];
    logic [15:0] last_rd = '0;
    logic [31:0] i_q [$];
    logic [15:0] d_q [$];
    beat_t       log_q [$];

    task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", n, act, exp);
        end
    endtask

    task automatic flag(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0h, expected %0h", n, act, exp);
    endtask

    function automatic logic [15:0] rom(input logic [31:0] a);
        case (a)
            32'h10:  return 16'hBEEF;
            32'h20:  return 16'h1234;
            32'h21:  return 16'h5678;
            default: return a[15:0] ^ a[31:16] ^ 16'hC3A5;
        endcase
    endfunction

    function automatic logic in_dreg(input logic [31:0] a);
        return a[31:4] == 28'h0000100;
    endfunction

    function automatic logic [15:0] ref_rd(input logic [31:0] a);
        return in_dreg(a) ? ref_dmem[a[3:0]] : rom(a);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_d(input logic wr, input logic [31:0] a, input logic [15:0] wd, output int cyc);
        logic [15:0] e;
        if (wr) begin
            e = last_rd;
            if (in_dreg(a)) ref_dmem[a[3:0]] = wd;
        end else begin
            e = ref_rd(a);
            last_rd = e;
        end
        d_q.push_back(e);
        d_wr = wr; d_addr = a; d_wdata = wd; d_req = 1'b1;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!d_done && cyc < 100);
        if (!d_done) begin
            flag("d_timeout", cyc, 0);
            d_q.delete(d_q.size() - 1);
        end
        d_req = 1'b0;
    endtask

    task automatic do_i(input logic [31:0] a, output int cyc);
        i_q.push_back({rom(a), rom(a + 32'd1)});
        i_addr = a; i_req = 1'b1;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!i_done && cyc < 100);
        if (!i_done) begin
            flag("i_timeout", cyc, 0);
            i_q.delete(i_q.size() - 1);
        end
        i_req = 1'b0;
    endtask

    task automatic chk_beat(input string n, input int idx, input logic [31:0] a, input logic w);
        if (idx < log_q.size())
            check(n, {31'd0, log_q[idx].w, log_q[idx].a}, {31'd0, w, a});
        else
            flag(n, log_q.size(), idx + 1);
    endtask

    // Memory responder: picks a latency per beat, acks, and stores writes on the ack edge.
    initial begin : memory
        int lat, cnt;
        bit fresh;
        logic [31:0] ba;
        logic bw;
        logic [15:0] bd;
        lat = 0; cnt = 0; fresh = 1'b1; ba = '0; bw = 1'b0; bd = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_ack) fresh = 1'b1;
            mem_ack = 1'b0;
            mem_rdata = 16'($urandom);
            if (!mem_req) begin
                fresh = 1'b1;
            end else begin
                if (fresh) begin
                    fresh = 1'b0; cnt = 0; ba = mem_addr; bw = mem_wr; bd = mem_wdata;
                    lat = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 3));
                end else begin
                    check("bus_stable", {15'd0, mem_addr, mem_wr, mem_wdata}, {15'd0, ba, bw, bd});
                end
                if (cnt == lat) begin
                    mem_ack = 1'b1;
                    if (in_dreg(mem_addr)) begin
                        if (mem_wr) dev_dmem[mem_addr[3:0]] = mem_wdata;
                        mem_rdata = dev_dmem[mem_addr[3:0]];
                    end else begin
                        mem_rdata = rom(mem_addr);
                    end
                end else begin
                    cnt++;
                end
            end
        end
    end

    initial begin : monitor
        logic prev_i, prev_d;
        beat_t b;
        prev_i = 1'b0; prev_d = 1'b0;
        forever begin
            @(negedge clk);
            check("i_stall", i_stall, i_req && !i_done);
            check("d_stall", d_stall, d_req && !d_done);
            if (mem_req && mem_ack) begin
                b.a = mem_addr; b.w = mem_wr; b.d = mem_wdata;
                log_q.push_back(b);
            end
            if (i_done) begin
                check("i_done_pulse", prev_i, 1'b0);
                if (i_q.size() == 0) flag("i_done_unexpected", i_instr, 0);
                else check("i_instr", i_instr, i_q.pop_front());
            end
            if (d_done) begin
                check("d_done_pulse", prev_d, 1'b0);
                if (d_q.size() == 0) flag("d_done_unexpected", d_rdata, 0);
                else check("d_rdata", d_rdata, d_q.pop_front());
            end
            prev_i = i_done;
            prev_d = d_done;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int c, cd, ci;
        for (int k = 0; k < 16; k++) begin
            dev_dmem[k] = 16'h0F00 + 16'(k) * 16'h0111;
            ref_dmem[k] = 16'h0F00 + 16'(k) * 16'h0111;
        end
        tick(3);
        check("rst_state", {mem_req, mem_wr, i_done, d_done, i_instr, d_rdata},
              {1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0});
        check("rst_bus", {mem_addr, mem_wdata}, 48'h0);
        rst = 1'b0;

        // Single D read, immediate ack: done two cycles after request.
        lat_force = 0; log_q.delete();
        do_d(1'b0, 32'h10, 16'h0, c);
        check("t1_lat", c, 2);
        chk_beat("t1_beat", 0, 32'h10, 1'b0);
        check("t1_rdata", d_rdata, 16'hBEEF);
        tick(2);

        // Two-beat fetch, each beat acked in its second cycle.
        lat_force = 1; log_q.delete();
        do_i(32'h20, c);
        check("t2_lat", c, 5);
        check("t2_instr", i_instr, 32'h12345678);
        check("t2_nbeats", log_q.size(), 2);
        chk_beat("t2_beat0", 0, 32'h20, 1'b0);
        chk_beat("t2_beat1", 1, 32'h21, 1'b0);
        tick(2);

        // Streak below the cap: D still wins a simultaneous request.
        lat_force = 0;
        i_addr = 32'h8000_0040; i_req = 1'b1; i_flush = 1'b1;
        for (int k = 0; k < 3; k++) do_d(1'b0, 32'h1000 + k, 16'h0, c);
        i_req = 1'b0; i_flush = 1'b0;
        tick(2); log_q.delete();
        fork
            do_d(1'b0, 32'h1001, 16'h0, cd);
            do_i(32'h8000_0040, ci);
        join
        chk_beat("t3a_first_d", 0, 32'h1001, 1'b0);
        chk_beat("t3a_then_i", 1, 32'h8000_0040, 1'b0);
        tick(2);

        // Streak saturated at the cap: I wins, then D.
        i_req = 1'b1; i_flush = 1'b1;
        for (int k = 0; k < 5; k++) do_d(1'b0, 32'h1004 + k, 16'h0, c);
        i_req = 1'b0; i_flush = 1'b0;
        tick(2); log_q.delete();
        fork
            do_d(1'b0, 32'h1002, 16'h0, cd);
            do_i(32'h8000_0040, ci);
        join
        chk_beat("t3b_first_i", 0, 32'h8000_0040, 1'b0);
        chk_beat("t3b_i_lo", 1, 32'h8000_0041, 1'b0);
        chk_beat("t3b_then_d", 2, 32'h1002, 1'b0);
        tick(2); log_q.delete();
        fork
            do_d(1'b0, 32'h1003, 16'h0, cd);
            do_i(32'h8000_0050, ci);
        join
        chk_beat("t3c_reset_d", 0, 32'h1003, 1'b0);
        tick(2);

        // Flush in I_HI while the beat is outstanding: beat drained, then pending D served.
        lat_force = 3; log_q.delete();
        i_addr = 32'h20; i_req = 1'b1;
        tick(1);
        check("t4_ihi", {mem_req, mem_addr}, {1'b1, 32'h20});
        fork
            do_d(1'b0, 32'h1003, 16'h0, cd);
            begin
                i_flush = 1'b1; i_req = 1'b0;
                tick(1);
                i_flush = 1'b0; lat_force = 0;
                for (int k = 0; k < 3; k++) begin
                    check("t4_hold", {mem_req, mem_addr}, {1'b1, 32'h20});
                    tick(1);
                end
            end
        join
        check("t4_d_lat", cd, 6);
        check("t4_nbeats", log_q.size(), 2);
        chk_beat("t4_beat0", 0, 32'h20, 1'b0);
        chk_beat("t4_beat1", 1, 32'h1003, 1'b0);
        tick(2);

        // Flush coinciding with the I_HI ack: straight back to IDLE.
        lat_force = 0; log_q.delete();
        i_addr = 32'h20; i_req = 1'b1;
        tick(1);
        i_flush = 1'b1; i_req = 1'b0;
        tick(1);
        i_flush = 1'b0;
        check("t4b_idle", mem_req, 1'b0);
        tick(3);
        check("t4b_nbeats", log_q.size(), 1);

        // Flush while waiting in I_LO.
        lat_force = 1; log_q.delete();
        i_addr = 32'h20; i_req = 1'b1;
        tick(3);
        check("t4c_ilo", {mem_req, mem_addr}, {1'b1, 32'h21});
        i_flush = 1'b1; i_req = 1'b0;
        tick(1);
        i_flush = 1'b0;
        check("t4c_drain", {mem_req, mem_addr}, {1'b1, 32'h21});
        tick(3);
        check("t4c_nbeats", log_q.size(), 2);
        check("t4c_idle", mem_req, 1'b0);

        // Flush in IDLE blocks the I grant that cycle.
        i_addr = 32'h20; i_req = 1'b1; i_flush = 1'b1;
        tick(1);
        i_req = 1'b0; i_flush = 1'b0;
        check("t4d_no_grant", mem_req, 1'b0);
        tick(2);

        // Flush during D_ACC leaves the data access untouched.
        fork
            do_d(1'b0, 32'h1002, 16'h0, cd);
            begin tick(1); i_flush = 1'b1; tick(1); i_flush = 1'b0; end
        join
        check("t4e_d_lat", cd, 3);
        tick(2);

        // Reset while D_ACC waits for its ack.
        lat_force = 5;
        d_addr = 32'h1005; d_wr = 1'b1; d_wdata = 16'h7777; d_req = 1'b1;
        tick(1);
        check("t5_dacc", {mem_req, mem_wr, mem_wdata}, {1'b1, 1'b1, 16'h7777});
        tick(1);
        rst = 1'b1; d_req = 1'b0; d_wr = 1'b0;
        tick(1);
        rst = 1'b0; last_rd = 16'h0;
        check("t5_ctl", {mem_req, mem_wr, i_done, d_done}, 4'b0000);
        check("t5_data", {i_instr, d_rdata}, 48'h0);
        check("t5_bus", {mem_addr, mem_wdata}, 48'h0);
        tick(8);

        // Address wrap on the second fetch beat; write leaves d_rdata alone.
        lat_force = -1; log_q.delete();
        do_i(32'hFFFF_FFFF, c);
        chk_beat("t6_beat0", 0, 32'hFFFF_FFFF, 1'b0);
        chk_beat("t6_wrap", 1, 32'h0000_0000, 1'b0);
        tick(1);
        do_d(1'b0, 32'h10, 16'h0, c);
        log_q.delete();
        do_d(1'b1, 32'h1007, 16'hA5A5, c);
        if (log_q.size() > 0) check("t6_wr_beat", {log_q[0].w, log_q[0].d}, {1'b1, 16'hA5A5});
        else flag("t6_wr_beat", 0, 1);
        check("t6_rdata_hold", d_rdata, 16'hBEEF);
        do_d(1'b0, 32'h1007, 16'h0, c);
        check("t6_readback", d_rdata, 16'hA5A5);
        tick(2);

        // Concurrent random traffic.
        fork
            begin
                int cc;
                logic [31:0] a;
                repeat (25) begin
                    tick($urandom_range(0, 4));
                    a = $urandom | 32'h8000_0000;
                    if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF;
                    do_i(a, cc);
                end
            end
            begin
                int cc;
                repeat (40) begin
                    tick($urandom_range(0, 3));
                    do_d(1'($urandom_range(0, 1)), 32'h1000 + $urandom_range(0, 15),
                         16'($urandom), cc);
                end
            end
        join
        tick(5);
        check("i_q_empty", i_q.size(), 0);
        check("d_q_empty", d_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
